// File: rtl/hilo_muldiv_unit_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_unit_pkg
// Brief   : Op and state encodings shared by the HI/LO multiply/divide unit.
// Revision: 1.0
// ============================================================================
package hilo_muldiv_unit_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Every encoding with bit 2 clear is an iterative mul/div.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_unit_datapath.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : muldiv_datapath
// Brief   : Shift-add multiply / restoring divide accumulator with sign fix.
// Revision: 1.0
// ============================================================================
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_signed,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;

    logic               w_dz;
    logic               w_sfix;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quo;

    // Divide by zero keeps the raw dividend and no sign fix, so the plain
    // restoring loop naturally yields quotient all-ones and remainder = rs.
    assign w_dz    = i_div && (i_rt == '0);
    assign w_sfix  = i_signed && !w_dz;
    assign w_mag_a = (w_sfix && i_rs[WIDTH-1]) ? -i_rs : i_rs;
    assign w_mag_b = (w_sfix && i_rt[WIDTH-1]) ? -i_rt : i_rt;

    // Multiply: high half accumulates, multiplier shifts out of the low half.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: high half is the partial remainder, low half shifts dividend
    // bits out and quotient bits in.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_b};
    assign w_fits     = !w_trial[WIDTH];
    assign w_div_next = {(w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_fits};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    assign o_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign o_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (i_load) begin
            r_acc    <= {{WIDTH{1'b0}}, (i_div ? w_mag_a : w_mag_b)};
            r_b      <= i_div ? w_mag_b : w_mag_a;
            r_is_div <= i_div;
            r_neg_q  <= w_sfix && (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
            r_neg_r  <= w_sfix && i_rs[WIDTH-1];
        end else if (i_step) begin
            r_acc    <= r_is_div ? w_div_next : w_mul_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_unit
// Brief   : HI/LO registers with iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO.
// Revision: 1.0
// ============================================================================
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;

    logic             w_load;
    logic             w_step;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_load = (r_state == ST_IDLE) && start && is_muldiv(op);
    assign w_step = (r_state == ST_CALC);

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_load),
        .i_step   (w_step),
        .i_signed (~op[0]),
        .i_div    (op[1]),
        .i_rs     (rs),
        .i_rt     (rt),
        .o_hi     (w_res_hi),
        .o_lo     (w_res_lo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MTHI: r_hi <= rs;
                            OP_MTLO: r_lo <= rs;
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                r_state <= ST_CALC;
                                r_cnt   <= '0;
                                r_busy  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_hilo_muldiv_unit
// Brief   : Vector table plus hand sequences with an expected-result queue.
// Revision: 1.0
// ============================================================================
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;

    int          total;
    int          bad;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    res_t        sb_q[$];
    vec_t        vecs[11];

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .rs    (rs),
        .rt    (rt),
        .HI    (HI),
        .LO    (LO),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; the op is presented for one cycle from here.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int inject_at);
        int   n;
        logic stable;
        res_t r;
        op = o; rs = a; rt = b; start = 1'b1;
        sb_q.push_back('{hi: eh, lo: el});
        @(negedge clk);
        start = 1'b0;
        check({name, "/done_low_at_start"}, 32'(done), 32'd0);
        n = 0;
        stable = 1'b1;
        while (busy && n < 40) begin
            if (HI !== m_hi || LO !== m_lo) stable = 1'b0;
            if (n == inject_at) begin
                op = OP_MTLO; rs = 32'hDEAD_BEEF; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check({name, "/busy_cycles"}, 32'(n), 32'd33);
        check({name, "/hilo_stable"}, 32'(stable), 32'd1);
        check({name, "/done_pulse"}, 32'(done), 32'd1);
        r = sb_q.pop_front();
        check({name, "/HI"}, HI, r.hi);
        check({name, "/LO"}, LO, r.lo);
        m_hi = r.hi;
        m_lo = r.lo;
    endtask

    task automatic do_mt(input string name, input logic [2:0] o, input logic [31:0] a);
        op = o; rs = a; start = 1'b1;
        if (o == OP_MTHI) m_hi = a;
        else m_lo = a;
        @(negedge clk);
        start = 1'b0;
        check({name, "/HI"}, HI, m_hi);
        check({name, "/LO"}, LO, m_lo);
        check({name, "/busy"}, 32'(busy), 32'd0);
        check({name, "/done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int dpulses;
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; op = 3'b000; rs = '0; rt = '0;

        vecs[0]  = '{"multu_max",   OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_neg3x5", OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{"div_neg7_2",  OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_100_7",  OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[4]  = '{"divu_by0",    OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[5]  = '{"div_ovf",     OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{"div_7_neg2",  OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{"mult_maxpos", OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[8]  = '{"mult_minneg", OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{"div_by0_neg", OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{"multu_zero",  OP_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};

        repeat (2) @(negedge clk);
        check("reset/HI", HI, 32'd0);
        check("reset/LO", LO, 32'd0);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/done", 32'(done), 32'd0);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);

        do_mt("mthi_init", OP_MTHI, 32'h11111111);
        do_mt("mtlo_init", OP_MTLO, 32'h22222222);

        // Asynchronous reset in the middle of a MULTU.
        op = OP_MULTU; rs = 32'hFFFFFFFF; rt = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("midcalc/busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midcalc/HI", HI, 32'd0);
        check("midcalc/LO", LO, 32'd0);
        check("midcalc/busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        dpulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dpulses++;
        end
        check("midcalc/no_done", 32'(dpulses), 32'd0);
        check("midcalc/busy_after", 32'(busy), 32'd0);

        // Table vectors issued back-to-back: each start lands in the done cycle.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt,
                   vecs[i].exp_hi, vecs[i].exp_lo, -1);
        end

        run_op("mult_then_mthi", OP_MULT, 32'hFFFFFFFD, 32'h00000005,
               32'hFFFFFFFF, 32'hFFFFFFF1, -1);
        do_mt("mthi_after_mult", OP_MTHI, 32'hABCDEF01);

        // MTLO presented while busy must be dropped.
        run_op("mult_mtlo_ignored", OP_MULT, 32'h00010001, 32'h00030003,
               32'h00000003, 32'h00060003, 5);
        @(negedge clk);
        check("final/done_low", 32'(done), 32'd0);
        check("final/LO_kept", LO, 32'h00060003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
